stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Instruction sequencer for the accumulator processor's execute stage (`topMod`). It fetches 16-bit instruction words from instruction memory and loads the stage registers `StageRegInstr_out`, `StageRegAddrMode_out`, `StageRegData_out` and `StageRegPCtr_out`. It then launches execution and waits for `StageComplete`, and advances the PC from `NextPctr`. It also handles one non-nesting interrupt level (vector `InteruptAdrReg`), the HALT/RETI opcodes and a stall watchdog.

## Interface
- `RESET_PC`, 8'h00, PC value after reset
- `STALL_LIMIT`, 15, max EXEC cycles without `StageComplete` before fault (range 1..255)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; one clock; the polarity and synchronicity are fixed
- `run`  in  1  level; enables sequencing at instruction boundaries
- `irq`  in  1  level interrupt request
- `InteruptAdrReg`  in  8  interrupt vector address
- `imem_addr`  out  8  instruction fetch address
- `imem_rd`  out  1  one-cycle fetch strobe
- `imem_rdata`  in  16  {instr[15:11], mode[10:8], data[7:0]}
- `imem_valid`  in  1  read data valid (variable latency ≥1)
- `StageRegInstr_out`  out  5  opcode to execute stage
- `StageRegAddrMode_out`  out  3  addressing mode
- `StageRegData_out`  out  8  operand / address field
- `StageRegPCtr_out`  out  8  PC of the staged instruction
- `stage_start`  out  1  one-cycle launch pulse
- `StageComplete`  in  1  execute stage done
- `NextPctr`  in  8  next PC from execute stage, valid with `StageComplete`
- `irq_ack`  out  1  one-cycle pulse on interrupt entry
- `in_isr`  out  1  interrupt service active
- `halted`  out  1  HALT state
- `fault`  out  1  watchdog fault, sticky

## Operation
- States: IDLE, FETCH, WAIT_MEM, ISSUE, EXEC, IRQ, HALT, FAULT.
- Reset values:
  - state IDLE, pc=`RESET_PC`, saved_pc=0, all stage registers 0, `imem_addr`=`RESET_PC`.
  - All 1-bit outputs 0.
- IDLE: if `run`=1, go to FETCH.
- FETCH: drive `imem_rd`=1 with `imem_addr`=pc for exactly one cycle, then go to WAIT_MEM.
- WAIT_MEM: wait for `imem_valid`. On valid:
  - Capture the fields into the stage registers and set `StageRegPCtr_out`=pc.
  - OP_HALT (5'b11111) goes to HALT; pc becomes pc+1 (8-bit wrap).
  - OP_RETI (5'b11110) sets pc=saved_pc and `in_isr`=0, then goes to the boundary check. No `stage_start` is issued.
  - Any other opcode goes to ISSUE.
- ISSUE: pulse `stage_start`, go to EXEC, clear the watchdog.
- EXEC: on `StageComplete`, set pc=`NextPctr` and go to the boundary check. Otherwise the watchdog increments; when it reaches `STALL_LIMIT`, go to FAULT.
- Boundary check (combinational choice of next state), in priority order:
  - `irq`=1 and `in_isr`=0: go to IRQ.
  - `run`=0: go to IDLE.
  - Otherwise: go to FETCH.
- IRQ: set saved_pc=pc, pc=`InteruptAdrReg`, `in_isr`=1, pulse `irq_ack`, go to FETCH.
- HALT: `halted`=1. If `irq`=1 and `in_isr`=0, go to IRQ (saved_pc = address after HALT). Otherwise stay in HALT until reset.
- FAULT: `fault`=1; stays until reset.
- No nesting: `irq` is ignored while `in_isr`=1, including in HALT.
- `StageComplete` and `imem_valid` are ignored outside EXEC and WAIT_MEM respectively.
- All PC arithmetic is 8-bit modulo 256.

## Timing
- Stage registers are registered outputs. They update only on the `imem_valid` capture edge and stay stable through ISSUE/EXEC until the next capture.
- `imem_valid` is sampled from the cycle after `imem_rd`; valid during the FETCH cycle is ignored.
- Minimum instruction time, with 1-cycle memory and `StageComplete` in the first EXEC cycle: 4 cycles, FETCH→WAIT_MEM→ISSUE→EXEC.
- `stage_start` is high in the ISSUE cycle only. `StageComplete` is accepted from the first EXEC cycle.
- Interrupt entry adds 1 cycle (IRQ). The first ISR fetch occurs in the cycle after `irq_ack`.
- Watchdog: with `StageComplete` never arriving, FAULT is entered exactly `STALL_LIMIT` cycles after entering EXEC. If `StageComplete` arrives in the limit cycle, completion wins.
- `run` falling mid-instruction has no effect until the boundary; the current instruction completes.
- Asserting `reset` in any state forces the reset values immediately (asynchronously), including a pending fetch; in-flight memory data arriving later is ignored.

## Structure
- Shared package/include `seq_pkg`:
  - State encoding.
  - OP_HALT and OP_RETI.
  - Instruction field slice positions (INSTR 15:11, MODE 10:8, DATA 7:0).
- One sub-module, `seq_watchdog`:
  - 8-bit counter with clear, enable and limit compare.
  - Outputs `expired`.
- Everything else (state register, PC and saved_pc, stage registers) lives in `stage_sequencer`.

## Test plan
- Straight-line code, 1-cycle memory, `StageComplete` in the first EXEC cycle, `NextPctr`=pc+1, `run`=1 from 0x00 → fetches 0x00, 0x01, 0x02 every 4 cycles; stage registers match memory; `StageRegPCtr_out` = fetch address.
- `irq` raised during EXEC at pc 0x05, `NextPctr`=0x06, vector 0x40 → `irq_ack` 1 cycle after completion; next fetch at 0x40; saved_pc=0x06; RETI at 0x41 → next fetch at 0x06, `in_isr`=0.
- Second `irq` held during the ISR → no re-entry until RETI; re-entry occurs at the RETI boundary with saved_pc = restored pc.
- HALT at 0x10 → `halted`=1 and no further `imem_rd`; `irq` → vector fetch; RETI returns to 0x11.
- `StageComplete` withheld with `STALL_LIMIT`=15 → `fault`=1 exactly 15 cycles after EXEC entry, sticky until `reset`.
- `reset` asserted in WAIT_MEM with a delayed `imem_valid` → all outputs return to reset values; the late data is not captured; restart fetches from `RESET_PC`.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the execute-stage instruction sequencer: state encoding,
// special opcodes and instruction word field positions.
package seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitMem,
    StIssue,
    StExec,
    StIrq,
    StHalt,
    StFault
  } seq_state_e;

  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [4:0] OP_RETI = 5'b11110;

  localparam int unsigned INSTR_MSB = 15;
  localparam int unsigned INSTR_LSB = 11;
  localparam int unsigned MODE_MSB  = 10;
  localparam int unsigned MODE_LSB  = 8;
  localparam int unsigned DATA_MSB  = 7;
  localparam int unsigned DATA_LSB  = 0;

  typedef struct packed {
    logic [4:0] instr;
    logic [2:0] mode;
    logic [7:0] data;
  } instr_t;

  function automatic instr_t decode_word(input logic [15:0] word);
    instr_t fields;
    fields.instr = word[INSTR_MSB:INSTR_LSB];
    fields.mode  = word[MODE_MSB:MODE_LSB];
    fields.data  = word[DATA_MSB:DATA_LSB];
    return fields;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags the cycle in
// which the count would reach the limit.
module seq_watchdog #(
  parameter int unsigned Limit = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [7:0] LastCnt = 8'(Limit - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counting the current stalled cycle, so the limit is hit one count early.
  assign expired_o = enable_i && (cnt_q == LastCnt);

endmodule

// File: rtl/stage_sequencer.sv
// Execute-stage instruction sequencer: fetch, stage, launch and retire instructions,
// with one non-nesting interrupt level, HALT/RETI handling and a stall watchdog.
module stage_sequencer
  import seq_pkg::*;
#(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        irq,
  input  logic [7:0]  InteruptAdrReg,
  output logic [7:0]  imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [4:0]  StageRegInstr_out,
  output logic [2:0]  StageRegAddrMode_out,
  output logic [7:0]  StageRegData_out,
  output logic [7:0]  StageRegPCtr_out,
  output logic        stage_start,
  input  logic        StageComplete,
  input  logic [7:0]  NextPctr,
  output logic        irq_ack,
  output logic        in_isr,
  output logic        halted,
  output logic        fault
);

  seq_state_e state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] saved_pc_q, saved_pc_d;
  logic       in_isr_q, in_isr_d;
  instr_t     stage_q, stage_d;
  logic [7:0] pctr_q, pctr_d;

  instr_t word;
  logic   wd_clear, wd_en, wd_expired;

  assign word = decode_word(imem_rdata);

  // Instruction-boundary decision; isr_active is passed in so RETI can use its cleared value.
  function automatic seq_state_e boundary(input logic irq_req, input logic run_req,
                                          input logic isr_active);
    if (irq_req && !isr_active) begin
      return StIrq;
    end else if (!run_req) begin
      return StIdle;
    end
    return StFetch;
  endfunction

  assign wd_clear = (state_q == StIssue);
  assign wd_en    = (state_q == StExec) && !StageComplete;

  seq_watchdog #(
    .Limit (STALL_LIMIT)
  ) u_watchdog (
    .clk_i     (clk),
    .rst_i     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_en),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    saved_pc_d = saved_pc_q;
    in_isr_d   = in_isr_q;
    stage_d    = stage_q;
    pctr_d     = pctr_q;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: state_d = StWaitMem;
      StWaitMem: begin
        if (imem_valid) begin
          stage_d = word;
          pctr_d  = pc_q;
          if (word.instr == OP_HALT) begin
            pc_d    = pc_q + 8'd1;
            state_d = StHalt;
          end else if (word.instr == OP_RETI) begin
            pc_d     = saved_pc_q;
            in_isr_d = 1'b0;
            state_d  = boundary(irq, run, 1'b0);
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StExec;
      StExec: begin
        if (StageComplete) begin
          pc_d    = NextPctr;
          state_d = boundary(irq, run, in_isr_q);
        end else if (wd_expired) begin
          state_d = StFault;
        end
      end
      StIrq: begin
        saved_pc_d = pc_q;
        pc_d       = InteruptAdrReg;
        in_isr_d   = 1'b1;
        state_d    = StFetch;
      end
      StHalt: begin
        if (irq && !in_isr_q) state_d = StIrq;
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      saved_pc_q <= '0;
      in_isr_q   <= 1'b0;
      stage_q    <= '0;
      pctr_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      saved_pc_q <= saved_pc_d;
      in_isr_q   <= in_isr_d;
      stage_q    <= stage_d;
      pctr_q     <= pctr_d;
    end
  end

  assign imem_addr            = pc_q;
  assign imem_rd              = (state_q == StFetch);
  assign stage_start          = (state_q == StIssue);
  assign irq_ack              = (state_q == StIrq);
  assign halted               = (state_q == StHalt);
  assign fault                = (state_q == StFault);
  assign in_isr               = in_isr_q;
  assign StageRegInstr_out    = stage_q.instr;
  assign StageRegAddrMode_out = stage_q.mode;
  assign StageRegData_out     = stage_q.data;
  assign StageRegPCtr_out     = pctr_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: memory and execute-stage responders plus an
// instruction-level reference model of the fetch order.
module tb_stage_sequencer;

  localparam logic [4:0] OpJmp  = 5'b00001;
  localparam logic [4:0] OpReti = 5'b11110;
  localparam logic [4:0] OpHalt = 5'b11111;

  logic        clk = 1'b0;
  logic        reset, run, irq;
  logic [7:0]  vec;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [4:0]  StageRegInstr_out;
  logic [2:0]  StageRegAddrMode_out;
  logic [7:0]  StageRegData_out;
  logic [7:0]  StageRegPCtr_out;
  logic        stage_start;
  logic        StageComplete;
  logic [7:0]  NextPctr;
  logic        irq_ack, in_isr, halted, fault;

  stage_sequencer #(
    .RESET_PC    (8'h00),
    .STALL_LIMIT (15)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .run                  (run),
    .irq                  (irq),
    .InteruptAdrReg       (vec),
    .imem_addr            (imem_addr),
    .imem_rd              (imem_rd),
    .imem_rdata           (imem_rdata),
    .imem_valid           (imem_valid),
    .StageRegInstr_out    (StageRegInstr_out),
    .StageRegAddrMode_out (StageRegAddrMode_out),
    .StageRegData_out     (StageRegData_out),
    .StageRegPCtr_out     (StageRegPCtr_out),
    .stage_start          (stage_start),
    .StageComplete        (StageComplete),
    .NextPctr             (NextPctr),
    .irq_ack              (irq_ack),
    .in_isr               (in_isr),
    .halted               (halted),
    .fault                (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [256];
  int          mem_lat = 1, ex_lat = 1;
  bit          mem_rand = 0, ex_rand = 0, ex_en = 1;
  int          mem_wait, ex_wait;
  logic [7:0]  mem_addr = 8'h00;
  logic [7:0]  ex_next;
  logic [7:0]  fetch_addr_q [$];
  int          fetch_cyc_q [$];
  int          ack_cyc_q [$];
  logic [23:0] stage_q [$];
  int          total = 0, bad = 0;

  // Instruction memory: data valid mem_wait cycles after the fetch strobe, junk otherwise.
  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    mem_wait   = 0;
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      imem_rdata = 16'($urandom);
      if (mem_wait > 0) begin
        mem_wait--;
        if (mem_wait == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem[mem_addr];
        end
      end
      if (imem_rd) begin
        mem_addr = imem_addr;
        mem_wait = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
        fetch_addr_q.push_back(imem_addr);
        fetch_cyc_q.push_back(cyc);
      end
      if (irq_ack) ack_cyc_q.push_back(cyc);
    end
  end

  // Execute stage: JMP goes to its data field, everything else to the next address.
  initial begin
    logic [15:0] w;
    StageComplete = 1'b0;
    NextPctr      = '0;
    ex_wait       = 0;
    forever begin
      @(negedge clk);
      StageComplete = 1'b0;
      NextPctr      = 8'($urandom);
      if (ex_wait > 0) begin
        ex_wait--;
        if (ex_wait == 0) begin
          StageComplete = 1'b1;
          NextPctr      = ex_next;
        end
      end
      if (stage_start) begin
        w = mem[mem_addr];
        stage_q.push_back({StageRegInstr_out, StageRegAddrMode_out, StageRegData_out,
                           StageRegPCtr_out});
        ex_next = (w[15:11] == OpJmp) ? w[7:0] : mem_addr + 8'd1;
        if (ex_en) ex_wait = ex_rand ? int'($urandom_range(1, 4)) : ex_lat;
      end
    end
  end

  function automatic logic [15:0] plain_word();
    return {5'($urandom_range(2, 29)), 3'($urandom), 8'($urandom)};
  endfunction

  task automatic do_reset();
    run = 1'b0;
    irq = 1'b0;
    repeat (25) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fetch_addr_q.delete();
    fetch_cyc_q.delete();
    ack_cyc_q.delete();
    stage_q.delete();
    mem_rand = 0; ex_rand = 0; mem_lat = 1; ex_lat = 1; ex_en = 1;
    vec = 8'h40;
    for (int a = 0; a < 256; a++) mem[a] = plain_word();
  endtask

  task automatic wait_fetches(input int n, input int budget, input bit rand_run, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fetch_addr_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      if (rand_run) run = ($urandom_range(0, 7) != 0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; irq = 1'b0; vec = 8'h40;
    repeat (2) @(negedge clk);
    total++;
    if (imem_addr !== 8'h00) begin
      bad++; $display("FAIL reset_addr: got %0h want 00", imem_addr);
    end
    total++;
    if ({StageRegInstr_out, StageRegAddrMode_out, StageRegData_out, StageRegPCtr_out} !== 24'h0)
    begin
      bad++; $display("FAIL reset_stage: got %0h want 0",
        {StageRegInstr_out, StageRegAddrMode_out, StageRegData_out, StageRegPCtr_out});
    end
    total++;
    if ({imem_rd, stage_start, irq_ack, in_isr, halted, fault} !== 6'b0) begin
      bad++; $display("FAIL reset_bits: got %b want 000000",
        {imem_rd, stage_start, irq_ack, in_isr, halted, fault});
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (imem_rd !== 1'b0) begin
        bad++; $display("FAIL idle_no_fetch: got %b want 0", imem_rd);
      end
    end
  endtask

  task automatic test_straight();
    bit ok;
    do_reset();
    run = 1'b1;
    wait_fetches(5, 100, 1'b0, ok);
    run = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (!ok || fetch_addr_q.size() != 5) begin
      bad++; $display("FAIL straight_count: got %0d fetches want 5", fetch_addr_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (fetch_addr_q[k] !== 8'(k)) begin
          bad++; $display("FAIL straight_addr[%0d]: got %0h want %0h", k, fetch_addr_q[k], k);
        end
        total++;
        if (stage_q[k] !== {mem[k], 8'(k)}) begin
          bad++; $display("FAIL straight_stage[%0d]: got %0h want %0h", k, stage_q[k],
                          {mem[k], 8'(k)});
        end
        if (k > 0) begin
          total++;
          if (fetch_cyc_q[k] - fetch_cyc_q[k-1] != 4) begin
            bad++; $display("FAIL straight_period[%0d]: got %0d want 4", k,
                            fetch_cyc_q[k] - fetch_cyc_q[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    bit          ok;
    logic [7:0]  pc, sp;
    logic [15:0] w;
    logic [7:0]  exp_f [$];
    logic [23:0] exp_s [$];
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        int r = int'($urandom_range(0, 15));
        mem[a] = plain_word();
        if (r == 0) mem[a][15:11] = OpJmp;
        else if (r == 1) mem[a][15:11] = OpReti;
      end
      exp_f.delete(); exp_s.delete();
      pc = 8'h00; sp = 8'h00;
      for (int k = 0; k < 24; k++) begin
        w = mem[pc];
        exp_f.push_back(pc);
        if (w[15:11] == OpReti) begin
          pc = sp;
        end else begin
          exp_s.push_back({w, pc});
          pc = (w[15:11] == OpJmp) ? w[7:0] : pc + 8'd1;
        end
      end
      mem_rand = 1; ex_rand = 1;
      wait_fetches(24, 3000, 1'b1, ok);
      run = 1'b0;
      repeat (20) @(negedge clk);
      total++;
      if (!ok || fetch_addr_q.size() != 24 || stage_q.size() != exp_s.size()) begin
        bad++; $display("FAIL random_count[%0d]: got %0d/%0d want 24/%0d", it,
                        fetch_addr_q.size(), stage_q.size(), exp_s.size());
      end else begin
        for (int k = 0; k < 24; k++) begin
          total++;
          if (fetch_addr_q[k] !== exp_f[k]) begin
            bad++; $display("FAIL random_addr[%0d][%0d]: got %0h want %0h", it, k,
                            fetch_addr_q[k], exp_f[k]);
          end
        end
        foreach (exp_s[k]) begin
          total++;
          if (stage_q[k] !== exp_s[k]) begin
            bad++; $display("FAIL random_stage[%0d][%0d]: got %0h want %0h", it, k,
                            stage_q[k], exp_s[k]);
          end
        end
      end
    end
  endtask

  task automatic test_irq();
    bit ok;
    int c;
    logic [7:0] exp_f [10];
    exp_f = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h40, 8'h41, 8'h06, 8'h07};
    do_reset();
    mem[8'h41] = {OpReti, 11'h0};
    run = 1'b1;
    ok = 1'b0;
    c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stage_start && StageRegPCtr_out == 8'h05) begin ok = 1'b1; c = cyc; break; end
    end
    irq = 1'b1;
    total++;
    if (!ok) begin bad++; $display("FAIL irq_issue_wait: timeout, want issue at pc 05"); end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (irq_ack) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || cyc != c + 2) begin
      bad++; $display("FAIL irq_ack_time: got cycle %0d (seen %0b) want %0d", cyc, ok, c + 2);
    end
    irq = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_rd, imem_addr, in_isr} !== {1'b1, 8'h40, 1'b1}) begin
      bad++; $display("FAIL irq_vector_fetch: got rd=%b addr=%0h isr=%b want 1 40 1",
                      imem_rd, imem_addr, in_isr);
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_rd && imem_addr == 8'h06) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || in_isr !== 1'b0) begin
      bad++; $display("FAIL irq_return: got seen=%b isr=%b want 1 0", ok, in_isr);
    end
    wait_fetches(10, 100, 1'b0, ok);
    run = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (fetch_addr_q.size() != 10 || ack_cyc_q.size() != 1) begin
      bad++; $display("FAIL irq_counts: got %0d fetches %0d acks want 10 1",
                      fetch_addr_q.size(), ack_cyc_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        total++;
        if (fetch_addr_q[k] !== exp_f[k]) begin
          bad++; $display("FAIL irq_addr[%0d]: got %0h want %0h", k, fetch_addr_q[k], exp_f[k]);
        end
      end
    end
  endtask

  task automatic test_nest();
    int acks;
    logic [7:0] exp_f [10];
    exp_f = '{8'h00, 8'h40, 8'h41, 8'h42, 8'h40, 8'h41, 8'h42, 8'h01, 8'h02, 8'h03};
    do_reset();
    mem[8'h42] = {OpReti, 11'h0};
    irq = 1'b1;
    run = 1'b1;
    acks = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (irq_ack) acks++;
      if (acks >= 2) irq = 1'b0;
      if (fetch_addr_q.size() >= 10) break;
    end
    run = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (fetch_addr_q.size() != 10 || ack_cyc_q.size() != 2) begin
      bad++; $display("FAIL nest_counts: got %0d fetches %0d acks want 10 2",
                      fetch_addr_q.size(), ack_cyc_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        total++;
        if (fetch_addr_q[k] !== exp_f[k]) begin
          bad++; $display("FAIL nest_addr[%0d]: got %0h want %0h", k, fetch_addr_q[k], exp_f[k]);
        end
      end
      total++;
      if (ack_cyc_q[1] != fetch_cyc_q[3] + 2) begin
        bad++; $display("FAIL nest_reti_reentry: got ack cycle %0d want %0d", ack_cyc_q[1],
                        fetch_cyc_q[3] + 2);
      end
      total++;
      if (fetch_cyc_q[4] != ack_cyc_q[1] + 1) begin
        bad++; $display("FAIL nest_vector_time: got %0d want %0d", fetch_cyc_q[4],
                        ack_cyc_q[1] + 1);
      end
    end
  endtask

  task automatic test_halt();
    bit ok;
    int rds;
    logic [7:0] exp_f [5];
    exp_f = '{8'h00, 8'h10, 8'h40, 8'h41, 8'h11};
    do_reset();
    mem[8'h00] = {OpJmp, 3'd0, 8'h10};
    mem[8'h10] = {OpHalt, 11'h0};
    mem[8'h41] = {OpReti, 11'h0};
    run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (halted) begin ok = 1'b1; break; end
    end
    rds = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_rd || !halted) rds++;
    end
    total++;
    if (!ok || rds != 0 || fetch_addr_q.size() != 2) begin
      bad++; $display("FAIL halt_hold: got seen=%b bad_cycles=%0d fetches=%0d want 1 0 2",
                      ok, rds, fetch_addr_q.size());
    end
    irq = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (irq_ack) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || halted !== 1'b0) begin
      bad++; $display("FAIL halt_irq_ack: got seen=%b halted=%b want 1 0", ok, halted);
    end
    irq = 1'b0;
    wait_fetches(5, 100, 1'b0, ok);
    run = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (!ok) begin
      bad++; $display("FAIL halt_resume: got %0d fetches want 5", fetch_addr_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        total++;
        if (fetch_addr_q[k] !== exp_f[k]) begin
          bad++; $display("FAIL halt_addr[%0d]: got %0h want %0h", k, fetch_addr_q[k], exp_f[k]);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int c, errs;
    do_reset();
    ex_lat = 15;
    run = 1'b1;
    ok = 1'b0; c = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (stage_start) begin ok = 1'b1; c = cyc; break; end
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_rd && imem_addr == 8'h01) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || fault !== 1'b0 || cyc != c + 16) begin
      bad++; $display("FAIL wd_limit_complete: got seen=%b fault=%b cycle=%0d want 1 0 %0d",
                      ok, fault, cyc, c + 16);
    end
    ex_en = 0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (stage_start) begin ok = 1'b1; c = cyc; break; end
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fault) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || cyc != c + 16) begin
      bad++; $display("FAIL wd_fault_time: got seen=%b cycle=%0d want 1 %0d", ok, cyc, c + 16);
    end
    irq = 1'b1;
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (!fault || imem_rd || irq_ack) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL wd_sticky: got %0d bad cycles want 0", errs);
    end
    irq = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL wd_reset_clear: got %b want 0", fault);
    end
  endtask

  task automatic test_reset_midfetch();
    bit ok;
    do_reset();
    run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (stage_start) begin ok = 1'b1; break; end
    end
    mem_lat = 5;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (imem_rd && imem_addr == 8'h01) break;
    end
    @(negedge clk);
    reset = 1'b1;
    run = 1'b0;
    #1;
    total++;
    if (!ok || {imem_addr, imem_rd, StageRegInstr_out, StageRegAddrMode_out, StageRegData_out,
                StageRegPCtr_out} !== 33'h0) begin
      bad++; $display("FAIL midfetch_async: got addr=%0h rd=%b stage=%0h want 0 0 0", imem_addr,
        imem_rd, {StageRegInstr_out, StageRegAddrMode_out, StageRegData_out, StageRegPCtr_out});
    end
    total++;
    if ({stage_start, irq_ack, in_isr, halted, fault} !== 5'b0) begin
      bad++; $display("FAIL midfetch_bits: got %b want 00000",
                      {stage_start, irq_ack, in_isr, halted, fault});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if ({StageRegInstr_out, StageRegAddrMode_out, StageRegData_out, StageRegPCtr_out} !== 24'h0)
    begin
      bad++; $display("FAIL midfetch_late_data: got %0h want 0",
        {StageRegInstr_out, StageRegAddrMode_out, StageRegData_out, StageRegPCtr_out});
    end
    mem_lat = 1;
    fetch_addr_q.delete();
    run = 1'b1;
    wait_fetches(1, 20, 1'b0, ok);
    run = 1'b0;
    total++;
    if (!ok || fetch_addr_q[0] !== 8'h00) begin
      bad++; $display("FAIL midfetch_restart: got seen=%b addr=%0h want 1 00", ok,
                      ok ? fetch_addr_q[0] : 8'hxx);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_straight();
    test_random();
    test_irq();
    test_nest();
    test_halt();
    test_watchdog();
    test_reset_midfetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
